message_decoder: RTL and testbench
==================================

# message_decoder

Receive-side counterpart of the bot's messaging unit. It consumes the ASCII byte stream delivered by the UART receiver at 115200 baud and parses it into decoded fault, pickup, deposit and end-of-run events. It validates every frame against the fixed message grammar and presents the decoded fields with a one-cycle strobe. Malformed or stalled frames are discarded, and the parser resynchronises on the next `#`.

## Interface
- `TIMEOUT_CYCLES`, default 50000: idle cycles allowed between bytes inside a frame before the frame is abandoned (about 11.5 byte times at 50 MHz). Must be in the range 1..65535.
- `clk_50M`  in  1  system clock, 50 MHz
- `rst_n`  in  1  asynchronous, active-low reset
- `rx_byte`  in  8  received ASCII byte; sampled only when `rx_valid`=1
- `rx_valid`  in  1  one-cycle strobe, one per received byte
- `msg_valid`  out  1  one-cycle pulse when a complete, legal frame has been decoded
- `msg_type`  out  2  0=FAULT (`FIM`), 1=PICKUP (`BPM`), 2=DEPOSIT (`BDM`), 3=END (`END`)
- `unit_id`  out  2  0=E, 1=C, 2=R; 0 for PICKUP and END
- `su_id`  out  2  supply-unit digit minus 1 (`'1'`→0 … `'4'`→3); 0 where the frame has no SU digit
- `block_id`  out  2  block digit minus 1; 0 where the frame has no block digit
- `frame_err`  out  1  one-cycle pulse when a frame is rejected
- `err_count`  out  8  count of rejected frames; saturates at 255
- `busy`  out  1  high while a frame is partially received (state ≠ IDLE)

## Operation
- Frame grammar. Here `u`∈{E,C,R} and `n`∈{1,2,3,4}.
  - FAULT: `F I M - u S U n - #` (10 bytes)
  - PICKUP: `B P M - S U - B n - #` (11 bytes)
  - DEPOSIT: `B D M - u S U n - B n - #` (13 bytes)
  - END: `E N D - #` (5 bytes)
- FSM states: IDLE, HDR1, HDR2, BODY, RESYNC.
  - A position index of 4 bits, together with a latched type, selects the expected character in BODY.
- IDLE transitions:
  - `F`, `B` or `E` → HDR1.
  - Any other non-zero byte → frame_err, then RESYNC.
  - `#` in IDLE is silently ignored.
- HDR1 and HDR2 resolve the type:
  - `F` must be followed by `I M`.
  - `B` must be followed by `P M` or `D M`.
  - `E` must be followed by `N D`.
- BODY compares each byte against the template for the latched type.
  - Variable positions (`u`, `n`) capture into shadow registers.
  - A mismatch raises frame_err. If the offending byte is `#`, the FSM goes to IDLE; otherwise it goes to RESYNC.
- RESYNC discards bytes until `#`, then returns to IDLE. It raises no further frame_err.
- Byte 0x00 is ignored in every state. It does not advance the FSM and does not reset the timeout counter.
- Final `#` matched:
  - Shadow registers are copied to the output fields, `msg_type` is set and `msg_valid` pulses.
  - Fields not present in the frame are driven to 0.
  - The FSM goes to IDLE.
- Output fields hold their values until the next `msg_valid`. Rejected frames never alter them.
- `err_count` increments by 1 on every frame_err pulse, holding at 255.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - FSM returns to IDLE.
  - All outputs go to 0: `msg_valid`, `frame_err`, `msg_type`, `unit_id`, `su_id`, `block_id`, `err_count`, `busy`.
  - Shadow registers and the timeout counter clear.
  - Reset mid-frame drops the partial frame with no frame_err.
- Latency:
  - `msg_valid` is asserted on the clock edge after the cycle in which `rx_valid`=1 carries the terminating `#`.
  - frame_err has the same 1-cycle latency after the offending byte.
  - All outputs are registered.
- Timeout counter:
  - Active only in HDR1, HDR2 and BODY. It clears on every non-zero `rx_valid` byte.
  - On reaching `TIMEOUT_CYCLES` the FSM goes to IDLE and frame_err pulses once.
  - In RESYNC a timeout returns the FSM to IDLE with no frame_err.
- Simultaneous events:
  - `rx_valid` in the same cycle as the timeout terminal count: the byte wins. It is processed normally and the counter clears.
- Back-to-back bytes: `rx_valid` may assert on consecutive cycles. Each byte is consumed in one cycle with no stall.
- A new frame may begin on the byte immediately after `#`.

## Test plan
- Send `FIM-CSU3-#` with bytes spaced 4340 cycles apart → one `msg_valid` pulse 1 cycle after `#`, with `msg_type`=0, `unit_id`=1, `su_id`=2, `block_id`=0; `err_count`=0.
- Send `BPM-SU-B4-#`, then `BDM-RSU1-B2-#`, then `END-#` back-to-back on consecutive cycles → three `msg_valid` pulses:
  - (1, `unit_id`=0, `su_id`=0, `block_id`=3)
  - (2, `unit_id`=2, `su_id`=0, `block_id`=1)
  - (3, all fields 0)
- Send `FIM-XSU1-#` → frame_err pulses 1 cycle after `X`; the remaining bytes up to `#` are discarded; no `msg_valid`; `err_count`=1.
  - Then send `END-#` → decoded normally.
- Send `BPM-S` and then leave `rx_valid` low for 50000 cycles → frame_err pulses once and `busy` drops.
  - With `rx_valid` low for only 49999 cycles, followed by `U-B1-#` → decodes correctly.
- Send 300 frames of `QQ#` → `err_count` saturates at 255; interleaved 0x00 bytes inside a valid frame are ignored.
- Assert `rst_n` low after `BDM-E` → all outputs 0 immediately. After release, `SU2-B1-#` yields only a frame_err (`S` seen in IDLE), and the next `END-#` decodes.

Source files
------------

// File: rtl/message_decoder.sv
// message_decoder: parses the received ASCII byte stream into FAULT/PICKUP/DEPOSIT/END events,
// rejecting malformed or stalled frames and resynchronising on the next '#'.
module message_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       msg_valid,
  output logic [1:0] msg_type,
  output logic [1:0] unit_id,
  output logic [1:0] su_id,
  output logic [1:0] block_id,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, HDR1, HDR2, BODY, RESYNC} state_t;
  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);
  // Body templates from the '-' after the header; u = unit letter, n = SU digit, b = block digit
  localparam logic [79:0] T_F = {"-uSUn-#", 24'h0};
  localparam logic [79:0] T_P = {"-SU-Bb-#", 16'h0};
  localparam logic [79:0] T_D = "-uSUn-Bb-#";
  localparam logic [79:0] T_E = {"-#", 64'h0};
  state_t state, nstate;
  logic [1:0] typ, ntyp, un_s, su_s, bl_s;
  logic [3:0] pos, npos;
  logic [15:0] cnt;
  logic [79:0] tpl;
  logic [7:0] exp_c;
  logic byte_ok, tmo, hit, err, done;
  assign byte_ok = rx_valid && rx_byte != 8'h00;
  assign tmo = state != IDLE && cnt == TMAX;
  assign tpl = (typ == 2'd0 ? T_F : typ == 2'd1 ? T_P : typ == 2'd2 ? T_D : T_E) << {pos, 3'b000};
  assign exp_c = tpl[79:72];
  // In HDR1 a 'B' frame is provisionally PICKUP until 'P' or 'D' resolves it
  assign hit = state == HDR1 ? (typ == 2'd0 ? rx_byte == "I" : typ == 2'd3 ? rx_byte == "N" : rx_byte inside {"P", "D"})
             : state == HDR2 ? rx_byte == (typ == 2'd3 ? "D" : "M")
             : exp_c == "u" ? rx_byte inside {"E", "C", "R"}
             : exp_c inside {"n", "b"} ? rx_byte inside {"1", "2", "3", "4"}
             : rx_byte == exp_c;
  always_comb begin
    nstate = state;
    ntyp = typ;
    npos = pos;
    err = 1'b0;
    done = 1'b0;
    if (byte_ok)
      case (state)
        IDLE:
          if (rx_byte inside {"F", "B", "E"}) begin
            nstate = HDR1;
            ntyp = rx_byte == "F" ? 2'd0 : rx_byte == "B" ? 2'd1 : 2'd3;
          end else if (rx_byte != "#") begin
            err = 1'b1;
            nstate = RESYNC;
          end
        RESYNC: if (rx_byte == "#") nstate = IDLE;
        default:
          if (!hit) begin
            err = 1'b1;
            nstate = rx_byte == "#" ? IDLE : RESYNC;
          end else if (state == HDR1) begin
            nstate = HDR2;
            ntyp = (typ == 2'd1 && rx_byte == "D") ? 2'd2 : typ;
          end else if (state == HDR2) begin
            nstate = BODY;
            npos = 4'd0;
          end else if (exp_c == "#") begin
            done = 1'b1;
            nstate = IDLE;
          end else npos = pos + 4'd1;
      endcase
    else if (tmo) begin
      nstate = IDLE;
      err = state != RESYNC;
    end
  end
  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      typ <= 2'd0;
      pos <= 4'd0;
      cnt <= 16'd0;
      un_s <= 2'd0;
      su_s <= 2'd0;
      bl_s <= 2'd0;
      msg_valid <= 1'b0;
      msg_type <= 2'd0;
      unit_id <= 2'd0;
      su_id <= 2'd0;
      block_id <= 2'd0;
      frame_err <= 1'b0;
      err_count <= 8'd0;
      busy <= 1'b0;
    end else begin
      state <= nstate;
      typ <= ntyp;
      pos <= npos;
      cnt <= (byte_ok || state == IDLE || tmo) ? 16'd0 : cnt + 16'd1;
      if (byte_ok && state == BODY && hit) begin
        if (exp_c == "u") un_s <= rx_byte == "E" ? 2'd0 : rx_byte == "C" ? 2'd1 : 2'd2;
        if (exp_c == "n") su_s <= rx_byte[1:0] - 2'd1;
        if (exp_c == "b") bl_s <= rx_byte[1:0] - 2'd1;
      end
      msg_valid <= done;
      frame_err <= err;
      busy <= nstate != IDLE;
      if (err && err_count != 8'hff) err_count <= err_count + 8'd1;
      if (done) begin
        msg_type <= typ;
        unit_id <= (typ == 2'd0 || typ == 2'd2) ? un_s : 2'd0;
        su_id <= (typ == 2'd0 || typ == 2'd2) ? su_s : 2'd0;
        block_id <= (typ == 2'd1 || typ == 2'd2) ? bl_s : 2'd0;
      end
    end
endmodule

// File: tb/tb_message_decoder.sv
// tb_message_decoder: directed frames for message_decoder with hand-computed results;
// the timeout is shortened (and byte spacing scaled 10x down) to keep the run short.
module tb_message_decoder;
  localparam int TO = 5000;
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic msg_valid, frame_err, busy;
  logic [1:0] msg_type, unit_id, su_id, block_id;
  logic [7:0] err_count;
  int checks = 0, errors = 0, nvalid = 0, nerr = 0, base, e0;
  logic [7:0] q[$];
  message_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_50M(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .msg_valid(msg_valid), .msg_type(msg_type), .unit_id(unit_id), .su_id(su_id),
    .block_id(block_id), .frame_err(frame_err), .err_count(err_count), .busy(busy)
  );
  always #10 clk = ~clk;
  always @(negedge clk) begin
    if (msg_valid) begin
      nvalid++;
      q.push_back({msg_type, unit_id, su_id, block_id});
    end
    if (frame_err) nerr++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic put(input logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask
  function automatic logic [7:0] qat(input int i);
    return i < q.size() ? q[i] : 8'hxx;
  endfunction
  initial begin
    idle(3);
    check("reset_outputs", {msg_valid, frame_err, msg_type, unit_id, su_id, block_id, err_count, busy}, 0);
    @(negedge clk) rst_n = 1'b1;
    idle(2);
    // FAULT with 434-cycle byte spacing
    for (int i = 0; i < 9; i++) begin
      put(("FIM-CSU3-#" >> (8 * (9 - i))) & 8'hff);
      check("fault_busy", busy, 1);
      idle(433);
    end
    put("#");
    check("fault_valid", msg_valid, 1);
    check("fault_fields", {msg_type, unit_id, su_id, block_id}, {2'd0, 2'd1, 2'd2, 2'd0});
    check("fault_errcnt", err_count, 0);
    idle(1);
    check("fault_pulse_width", msg_valid, 0);
    check("fault_count", nvalid, 1);
    // three frames back to back
    base = q.size();
    send("BPM-SU-B4-#BDM-RSU1-B2-#END-#");
    idle(2);
    check("b2b_count", q.size() - base, 3);
    check("b2b_pickup", qat(base), {2'd1, 2'd0, 2'd0, 2'd3});
    check("b2b_deposit", qat(base + 1), {2'd2, 2'd2, 2'd0, 2'd1});
    check("b2b_end", qat(base + 2), {2'd3, 2'd0, 2'd0, 2'd0});
    // bad unit letter
    base = nvalid;
    e0 = nerr;
    send("FIM-");
    check("badu_no_err_yet", frame_err, 0);
    put("X");
    check("badu_err", frame_err, 1);
    check("badu_errcnt", err_count, 1);
    send("SU1-#");
    check("badu_idle", busy, 0);
    check("badu_one_err", nerr - e0, 1);
    check("badu_no_valid", nvalid - base, 0);
    check("badu_fields_held", {msg_type, unit_id, su_id, block_id}, {2'd3, 2'd0, 2'd0, 2'd0});
    send("END-#");
    check("badu_end_valid", msg_valid, 1);
    check("badu_end_type", msg_type, 3);
    // timeout after TO idle cycles
    e0 = nerr;
    send("BPM-S");
    idle(TO - 1);
    check("tmo_not_yet", {frame_err, busy}, 2'b01);
    idle(1);
    check("tmo_err", {frame_err, busy}, 2'b10);
    check("tmo_errcnt", err_count, 2);
    idle(1);
    check("tmo_one_err", nerr - e0, 1);
    // byte arriving on the terminal count wins
    e0 = nerr;
    send("BPM-S");
    idle(TO - 1);
    send("U-B1-#");
    check("tmo_edge_valid", msg_valid, 1);
    check("tmo_edge_fields", {msg_type, unit_id, su_id, block_id}, {2'd1, 2'd0, 2'd0, 2'd0});
    check("tmo_edge_no_err", nerr - e0, 0);
    // NUL bytes are ignored everywhere
    e0 = nerr;
    put(8'h00);
    put("E");
    put(8'h00);
    put("N");
    put(8'h00);
    put(8'h00);
    send("D-");
    put(8'h00);
    put("#");
    check("nul_valid", msg_valid, 1);
    check("nul_type", msg_type, 3);
    check("nul_no_err", nerr - e0, 0);
    // error counter saturation
    e0 = nerr;
    for (int i = 0; i < 300; i++) send("QQ#");
    idle(1);
    check("sat_errcnt", err_count, 255);
    check("sat_pulses", nerr - e0, 300);
    // asynchronous reset mid-frame
    send("BDM-E");
    #3 rst_n = 1'b0;
    #1;
    check("rst_outputs", {msg_valid, frame_err, msg_type, unit_id, su_id, block_id, err_count, busy}, 0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);
    base = nvalid;
    put("S");
    check("rst_s_err", frame_err, 1);
    check("rst_errcnt", err_count, 1);
    send("U2-B1-#");
    check("rst_no_valid", nvalid - base, 0);
    send("END-#");
    check("rst_end_valid", msg_valid, 1);
    check("rst_end_fields", {msg_type, unit_id, su_id, block_id}, {2'd3, 2'd0, 2'd0, 2'd0});
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
